// File: rtl/pe_mem_access_param.sv
// -----------------------------------------------------------------------------
// pe_mem_access_param
//
// Memory-access processing element for the CGRA array. Combines a
// REG_COUNT-deep register file, a single-cycle ALU and a cache-port
// controller with a request/acknowledge handshake. While a load or store
// is outstanding the PE sits in WAIT (STALL_O high) and ignores its
// context; the transaction ends on CACHE_ACK_I or, if TIMEOUT > 0, is
// aborted after TIMEOUT unacknowledged cycles, which sets the sticky ERR_O.
//
// Parameters
//   DATA_WIDTH        datapath / register width
//   REG_COUNT         register-file depth (>= 2)
//   CACHE_ADDR_WIDTH  cache address width (<= DATA_WIDTH)
//   TIMEOUT           max WAIT cycles before abort, 0 = never abort
//
// Ports
//   CLK_I, RST_I           clock, asynchronous active-high reset
//   EN_GLOBAL_I, CTX_EN_I  array-wide and per-PE enables
//   OP_I                   0 NOP 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 LOAD 7 STORE
//   MUX_A_I, MUX_B_I       operand select: 0 INPUT_0_I, 1 reg[RD_MUX_ADDR_I]
//   REGSRC_I               write source: 0 ALU result, 1 AMIDAR_I
//   RD_*_ADDR_I, WR_ADDR_I register-file addresses
//   WR_EN_I, COND_WR_I     write enable, predicate-gated write
//   COND_MEM_I, PBOX_I     predicate-gated memory op, predicate
//   INPUT_0_I, AMIDAR_I    operand and host data
//   CACHE_ACK_I/RDATA_I    cache acknowledge and load data
//   CACHE_REQ_O/WR_O/ADDR_O/WDATA_O  registered cache request
//   DIRECT_O, DATA_O       combinational register-file reads
//   STATUS_O               registered zero flag of the last ALU op
//   STALL_O                high while a memory transaction is outstanding
//   ERR_O                  sticky timeout flag
// -----------------------------------------------------------------------------
module pe_mem_access_param #(
    parameter int  DATA_WIDTH       = 32,
    parameter int  REG_COUNT        = 16,
    parameter int  CACHE_ADDR_WIDTH = 32,
    parameter int  TIMEOUT          = 0,
    localparam int AW               = $clog2(REG_COUNT)
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        EN_GLOBAL_I,
    input  logic                        CTX_EN_I,
    input  logic [2:0]                  OP_I,
    input  logic                        MUX_A_I,
    input  logic                        MUX_B_I,
    input  logic                        REGSRC_I,
    input  logic [AW-1:0]               RD_MUX_ADDR_I,
    input  logic [AW-1:0]               RD_DIRECT_ADDR_I,
    input  logic [AW-1:0]               RD_CACHE_ADDR_I,
    input  logic [AW-1:0]               WR_ADDR_I,
    input  logic                        WR_EN_I,
    input  logic                        COND_WR_I,
    input  logic                        COND_MEM_I,
    input  logic                        PBOX_I,
    input  logic [DATA_WIDTH-1:0]       INPUT_0_I,
    input  logic [DATA_WIDTH-1:0]       AMIDAR_I,
    input  logic                        CACHE_ACK_I,
    input  logic [DATA_WIDTH-1:0]       CACHE_RDATA_I,
    output logic                        CACHE_REQ_O,
    output logic                        CACHE_WR_O,
    output logic [CACHE_ADDR_WIDTH-1:0] CACHE_ADDR_O,
    output logic [DATA_WIDTH-1:0]       CACHE_WDATA_O,
    output logic [DATA_WIDTH-1:0]       DIRECT_O,
    output logic [DATA_WIDTH-1:0]       DATA_O,
    output logic                        STATUS_O,
    output logic                        STALL_O,
    output logic                        ERR_O
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_LOAD  = 3'd6;
    localparam logic [2:0] OP_STORE = 3'd7;

    // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit
    // so the declaration stays legal when the timeout is disabled.
    localparam int            TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // ALU: ADD/SUB wrap modulo 2^DATA_WIDTH, logic ops are bitwise.
    function automatic logic [DATA_WIDTH-1:0] alu_f(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // State
    state_e                        state_q, state_d;
    logic [DATA_WIDTH-1:0]         rf_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]         rf_d [REG_COUNT];
    logic                          req_q, req_d;
    logic                          wr_q, wr_d;
    logic [CACHE_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
    logic                          status_q, status_d;
    logic                          err_q, err_d;
    logic [AW-1:0]                 pend_addr_q, pend_addr_d;
    logic                          pend_ld_q, pend_ld_d;
    logic [TW-1:0]                 tmo_cnt_q, tmo_cnt_d;

    // Decoded control and datapath
    logic                          en;
    logic                          wr_ok;
    logic                          mem_ok;
    logic [DATA_WIDTH-1:0]         mux_rd;
    logic [DATA_WIDTH-1:0]         op_a;
    logic [DATA_WIDTH-1:0]         op_b;
    logic [DATA_WIDTH-1:0]         alu_res;
    logic [CACHE_ADDR_WIDTH-1:0]   cache_addr;

    assign en     = EN_GLOBAL_I & CTX_EN_I;
    assign wr_ok  = WR_EN_I & (~COND_WR_I | PBOX_I);
    assign mem_ok = ~COND_MEM_I | PBOX_I;

    // Register-file reads are purely combinational: a write becomes visible
    // only after the edge that performs it.
    assign mux_rd     = rf_q[RD_MUX_ADDR_I];
    assign DATA_O     = mux_rd;
    assign DIRECT_O   = rf_q[RD_DIRECT_ADDR_I];
    assign cache_addr = CACHE_ADDR_WIDTH'(rf_q[RD_CACHE_ADDR_I]);

    assign op_a    = MUX_A_I ? mux_rd : INPUT_0_I;
    assign op_b    = MUX_B_I ? mux_rd : INPUT_0_I;
    assign alu_res = alu_f(OP_I, op_a, op_b);

    assign CACHE_REQ_O   = req_q;
    assign CACHE_WR_O    = wr_q;
    assign CACHE_ADDR_O  = addr_q;
    assign CACHE_WDATA_O = wdata_q;
    assign STATUS_O      = status_q;
    assign STALL_O       = (state_q == ST_WAIT);
    assign ERR_O         = err_q;

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        req_d       = req_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        status_d    = status_q;
        err_d       = err_q;
        pend_addr_d = pend_addr_q;
        pend_ld_d   = pend_ld_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    case (OP_I)
                        OP_NOP: begin
                            // NOP still lets the host push data into a register.
                            if (wr_ok && REGSRC_I) begin
                                rf_d[WR_ADDR_I] = AMIDAR_I;
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            // A predicated-off memory op degrades to a plain NOP
                            // without the host-write side effect.
                            if (mem_ok) begin
                                addr_d      = cache_addr;
                                wdata_d     = op_a;
                                wr_d        = (OP_I == OP_STORE);
                                req_d       = 1'b1;
                                pend_addr_d = WR_ADDR_I;
                                pend_ld_d   = wr_ok && (OP_I == OP_LOAD);
                                tmo_cnt_d   = '0;
                                state_d     = ST_WAIT;
                            end
                        end
                        default: begin
                            if (wr_ok) begin
                                rf_d[WR_ADDR_I] = REGSRC_I ? AMIDAR_I : alu_res;
                            end
                            status_d = (alu_res == '0);
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                // Context and enables are ignored here: the transaction always
                // runs to ack or timeout. Ack has priority over expiry.
                if (CACHE_ACK_I) begin
                    req_d     = 1'b0;
                    wr_d      = 1'b0;
                    pend_ld_d = 1'b0;
                    if (pend_ld_q) begin
                        rf_d[pend_addr_q] = CACHE_RDATA_I;
                    end
                    state_d = ST_IDLE;
                end else if (TIMEOUT > 0) begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        req_d     = 1'b0;
                        wr_d      = 1'b0;
                        pend_ld_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            status_q    <= 1'b0;
            err_q       <= 1'b0;
            pend_addr_q <= '0;
            pend_ld_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            status_q    <= status_d;
            err_q       <= err_d;
            pend_addr_q <= pend_addr_d;
            pend_ld_q   <= pend_ld_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule
